// File: rtl/branch_resolve_if.sv
// Pipeline-to-branch-unit bundle: ID/EX instruction inputs and resolver responses.
// The pipeline side uses the master modport; branch_resolve uses the slave modport.
interface branch_resolve_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
);
  logic             i_valid;
  logic             i_stall;
  logic             i_kill;
  logic             i_is_br;
  logic             i_is_jal;
  logic             i_is_jalr;
  logic [2:0]       i_funct3;
  logic [N-1:0]     i_pc;
  logic [N-1:0]     i_imm;
  logic [N-1:0]     i_rs1;
  logic [N-1:0]     i_rs2;

  logic             o_redirect;
  logic [N-1:0]     o_target;
  logic [N-1:0]     o_link;
  logic             o_flush;
  logic             o_illegal;
  logic             o_misalign;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_tk_cnt;

  modport master (
    output i_valid, i_stall, i_kill, i_is_br, i_is_jal, i_is_jalr, i_funct3,
           i_pc, i_imm, i_rs1, i_rs2,
    input  o_redirect, o_target, o_link, o_flush, o_illegal, o_misalign,
           o_br_cnt, o_tk_cnt
  );

  modport slave (
    input  i_valid, i_stall, i_kill, i_is_br, i_is_jal, i_is_jalr, i_funct3,
           i_pc, i_imm, i_rs1, i_rs2,
    output o_redirect, o_target, o_link, o_flush, o_illegal, o_misalign,
           o_br_cnt, o_tk_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolver: evaluates conditions, issues a registered redirect and
// squashes SHADOW wrong-path slots afterwards; also counts evaluated and taken branches.
module branch_resolve #(
  parameter int unsigned N      = 32,
  parameter int unsigned SHADOW = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  branch_resolve_if.slave bus
);

  localparam int unsigned SqW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

  typedef enum logic [0:0] {StRun, StSquash} state_e;

  state_e           state_q;
  logic [SqW-1:0]   sq_cnt_q;
  logic             redirect_q;
  logic [N-1:0]     target_q;
  logic [N-1:0]     link_q;
  logic             illegal_q;
  logic             misalign_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] tk_cnt_q;

  logic         sel_jalr, sel_jal, sel_br, is_ctrl;
  logic         cond, bad_f3, taken, do_redirect, do_misalign;
  logic         slt, ult;
  logic [N-1:0] jalr_sum, target_d;

  // Class priority when several flags are set: JALR > JAL > BR.
  always_comb begin
    sel_jalr = bus.i_is_jalr;
    sel_jal  = bus.i_is_jal & ~bus.i_is_jalr;
    sel_br   = bus.i_is_br & ~bus.i_is_jal & ~bus.i_is_jalr;
    is_ctrl  = sel_jalr | sel_jal | sel_br;
  end

  always_comb begin
    slt    = $signed(bus.i_rs1) < $signed(bus.i_rs2);
    ult    = bus.i_rs1 < bus.i_rs2;
    cond   = 1'b0;
    bad_f3 = 1'b0;
    case (bus.i_funct3)
      3'b000:  cond = (bus.i_rs1 == bus.i_rs2);
      3'b001:  cond = (bus.i_rs1 != bus.i_rs2);
      3'b100:  cond = slt;
      3'b101:  cond = ~slt;
      3'b110:  cond = ult;
      3'b111:  cond = ~ult;
      default: bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    jalr_sum    = bus.i_rs1 + bus.i_imm;
    target_d    = sel_jalr ? {jalr_sum[N-1:1], 1'b0} : (bus.i_pc + bus.i_imm);
    taken       = sel_jalr | sel_jal | (sel_br & cond);
    do_misalign = taken & target_d[1];
    do_redirect = taken & ~target_d[1];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StRun;
      sq_cnt_q   <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      link_q     <= '0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      // Pulses default low; only an accepted instruction in RUN raises them.
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      if (bus.i_kill) begin
        state_q  <= StRun;
        sq_cnt_q <= '0;
      end else if (!bus.i_stall) begin
        unique case (state_q)
          StRun: begin
            if (bus.i_valid && is_ctrl) begin
              target_q   <= target_d;
              redirect_q <= do_redirect;
              misalign_q <= do_misalign;
              illegal_q  <= sel_br & bad_f3;
              if (sel_jal || sel_jalr) link_q <= bus.i_pc + N'(4);
              if (sel_br && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
              if (sel_br && cond && tk_cnt_q != '1) tk_cnt_q <= tk_cnt_q + 1'b1;
              if (do_redirect && SHADOW > 0) begin
                state_q  <= StSquash;
                sq_cnt_q <= SqW'(SHADOW);
              end
            end
          end
          StSquash: begin
            // Wrong-path slots are dropped; leave once the last slot has passed.
            if (sq_cnt_q <= SqW'(1)) begin
              state_q  <= StRun;
              sq_cnt_q <= '0;
            end else begin
              sq_cnt_q <= sq_cnt_q - 1'b1;
            end
          end
          default: begin
            state_q  <= StRun;
            sq_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_redirect = redirect_q;
  assign bus.o_target   = target_q;
  assign bus.o_link     = link_q;
  assign bus.o_flush    = (state_q == StSquash);
  assign bus.o_illegal  = illegal_q;
  assign bus.o_misalign = misalign_q;
  assign bus.o_br_cnt   = br_cnt_q;
  assign bus.o_tk_cnt   = tk_cnt_q;

endmodule
